// File: rtl/mips32_if_prefetch.sv
// MIPS32 instruction-fetch stage: owns the PC, issues word reads to instruction memory and
// buffers returned instructions in an in-order prefetch FIFO with a valid/ready decode handshake.
module mips32_if_prefetch #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [5:0]        HALT_OP  = 6'h3f
) (
    input  logic              clk1,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              id_ready,
    output logic              if_valid,
    output logic [31:0]       if_ir,
    output logic [ADDR_W-1:0] if_npc,
    output logic              halted
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CW-1:0]     out_q, out_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     trk_rd_q, trk_rd_d, trk_wr_q, trk_wr_d;
    logic              halt_seen_q, halt_seen_d;
    logic              halted_q, halted_d;

    logic [31:0]       fifo_ir_q  [DEPTH];
    logic [ADDR_W-1:0] fifo_npc_q [DEPTH];
    logic [ADDR_W-1:0] trk_q      [DEPTH];

    logic              redir, issue, ret, ret_drop, push, push_halt, pop, head_halt, flush;
    logic [CW:0]       occupancy;

    // Handshake and event decode
    always_comb begin
        redir     = redirect_valid && !halted_q;
        occupancy = {1'b0, out_q} + {1'b0, cnt_q};
        issue     = rst_n && !halted_q && !halt_seen_q && !redirect_valid &&
                    (occupancy < (CW+1)'(DEPTH));
        ret       = imem_rvalid && !halted_q;
        ret_drop  = ret && (drop_q != '0);
        push      = ret && !ret_drop && !redir;
        push_halt = push && (imem_rdata[31:26] == HALT_OP);
        if_valid  = !halted_q && (cnt_q != '0);
        pop       = if_valid && id_ready && !redir;
        head_halt = fifo_ir_q[rd_ptr_q][31:26] == HALT_OP;
        flush     = redir || (pop && head_halt);
    end

    always_comb begin
        imem_req  = issue;
        imem_addr = pc_q;
        if_ir     = if_valid ? fifo_ir_q[rd_ptr_q] : '0;
        if_npc    = if_valid ? fifo_npc_q[rd_ptr_q] : '0;
        halted    = halted_q;
    end

    always_comb begin
        pc_d        = pc_q;
        out_d       = out_q;
        drop_d      = drop_q;
        cnt_d       = cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        trk_wr_d    = trk_wr_q;
        trk_rd_d    = trk_rd_q;
        halt_seen_d = halt_seen_q;
        halted_d    = halted_q;

        if (issue) begin
            pc_d     = pc_q + ADDR_W'(1);
            out_d    = out_d + CW'(1);
            trk_wr_d = trk_wr_q + PW'(1);
        end
        if (ret) begin
            out_d    = out_d - CW'(1);
            trk_rd_d = trk_rd_q + PW'(1);
        end
        if (ret_drop) drop_d = drop_q - CW'(1);
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            cnt_d    = cnt_d + CW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            cnt_d    = cnt_d - CW'(1);
            if (head_halt) halted_d = 1'b1;
        end
        // Anything still in flight behind a HALT belongs to the dead stream
        if (push_halt) begin
            halt_seen_d = 1'b1;
            drop_d      = out_d;
        end
        if (flush) begin
            rd_ptr_d = wr_ptr_d;
            cnt_d    = '0;
        end
        if (redir) begin
            pc_d        = redirect_pc;
            drop_d      = out_d;
            halt_seen_d = 1'b0;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            out_q       <= '0;
            drop_q      <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            trk_wr_q    <= '0;
            trk_rd_q    <= '0;
            halt_seen_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            out_q       <= out_d;
            drop_q      <= drop_d;
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            trk_wr_q    <= trk_wr_d;
            trk_rd_q    <= trk_rd_d;
            halt_seen_q <= halt_seen_d;
            halted_q    <= halted_d;
        end
    end

    // Storage only; validity is tracked by the pointers and counters above
    always_ff @(posedge clk1) begin
        if (issue) trk_q[trk_wr_q] <= pc_q;
        if (push) begin
            fifo_ir_q[wr_ptr_q]  <= imem_rdata;
            fifo_npc_q[wr_ptr_q] <= trk_q[trk_rd_q] + ADDR_W'(1);
        end
    end

    a_no_spurious_return: assert property (@(posedge clk1) disable iff (!rst_n)
        !(imem_rvalid && !halted_q && (out_q == '0)));

endmodule

// File: tb/tb_mips32_if_prefetch.sv
// Bench for mips32_if_prefetch: in-order memory model with configurable latency, a queue-based
// reference model compared every cycle, and directed scenarios with literal expectations.
module tb_mips32_if_prefetch;
    localparam int unsigned DEPTH = 2;
    localparam logic [5:0]  HALT  = 6'h3f;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic        if_valid;
    logic [31:0] if_ir;
    logic [31:0] if_npc;
    logic        halted;

    mips32_if_prefetch #(.ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .HALT_OP(HALT)) dut (
        .clk1(clk1), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .id_ready(id_ready), .if_valid(if_valid), .if_ir(if_ir),
        .if_npc(if_npc), .halted(halted)
    );

    always #5 clk1 = ~clk1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lat      = 1;

    typedef struct {logic [31:0] addr; int due;} mreq_t;
    mreq_t       mq[$];
    mreq_t       mh;
    logic [31:0] req_log[$];
    logic [31:0] xfer_ir[$];
    logic [31:0] xfer_npc[$];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        case (a)
            32'd0:   return 32'h2801000a;
            32'd1:   return 32'h28020014;
            32'd2:   return 32'h28030019;
            32'd3:   return 32'hfc000000;
            32'd5:   return 32'h00222000;
            32'd8:   return 32'hfc000000;
            default: return {16'h2400, a[15:0]};
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk1);
        #1;
    endtask

    task automatic do_reset(input int l, input logic rdy);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        id_ready       = rdy;
        lat            = l;
        step(2);
        req_log.delete();
        xfer_ir.delete();
        xfer_npc.delete();
        rst_n = 1'b1;
    endtask

    task automatic run_until_halt(input int budget);
        for (int i = 0; i < budget && !halted; i++) step(1);
        chk("halt_reached", 64'(halted), 64'd1);
    endtask

    task automatic chk_prog();
        chk("xfer_count", 64'(xfer_ir.size()), 64'd4);
        if (xfer_ir.size() == 4) begin
            chk("xfer0_ir", 64'(xfer_ir[0]), 64'h2801000a);
            chk("xfer1_ir", 64'(xfer_ir[1]), 64'h28020014);
            chk("xfer2_ir", 64'(xfer_ir[2]), 64'h28030019);
            chk("xfer3_ir", 64'(xfer_ir[3]), 64'hfc000000);
            for (int i = 0; i < 4; i++) chk("xfer_npc", 64'(xfer_npc[i]), 64'(i + 1));
        end
    endtask

    initial forever begin
        @(posedge clk1);
        cyc++;
    end

    // Memory returns: in order, at least lat cycles after the request
    initial forever begin
        @(posedge clk1);
        #2;
        if (!rst_n) begin
            mq.delete();
            imem_rvalid = 1'b0;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            mh          = mq.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = mem_rd(mh.addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    end

    // Reference model: what decode and memory must see, from the fetch rules
    logic [31:0] m_pc = '0;
    logic [31:0] m_outq[$];
    logic [31:0] m_fir[$];
    logic [31:0] m_fnpc[$];
    int          m_drop = 0;
    bit          m_hseen = 0;
    bit          m_halted = 0;

    initial forever begin
        logic        e_req, e_valid, xfer, hpush;
        logic [31:0] e_ir, e_npc, a, hd;
        @(negedge clk1);
        if (!rst_n) begin
            m_pc = '0; m_outq.delete(); m_fir.delete(); m_fnpc.delete();
            m_drop = 0; m_hseen = 0; m_halted = 0;
            e_req = 1'b0;
        end else begin
            e_req = !m_halted && !m_hseen && !redirect_valid &&
                    (m_outq.size() + m_fir.size() < DEPTH);
        end
        e_valid = !m_halted && m_fir.size() > 0;
        e_ir    = e_valid ? m_fir[0] : '0;
        e_npc   = e_valid ? m_fnpc[0] : '0;
        chk("imem_req", 64'(imem_req), 64'(e_req));
        chk("imem_addr", 64'(imem_addr), 64'(m_pc));
        chk("if_valid", 64'(if_valid), 64'(e_valid));
        chk("if_ir", 64'(if_ir), 64'(e_ir));
        chk("if_npc", 64'(if_npc), 64'(e_npc));
        chk("halted", 64'(halted), 64'(m_halted));

        if (rst_n && imem_req) begin
            mq.push_back('{addr: imem_addr, due: cyc + lat});
            req_log.push_back(imem_addr);
        end
        if (rst_n && if_valid && id_ready && !redirect_valid) begin
            xfer_ir.push_back(if_ir);
            xfer_npc.push_back(if_npc);
        end

        if (rst_n && !m_halted) begin
            xfer  = e_valid && id_ready && !redirect_valid;
            hpush = 1'b0;
            if (xfer) begin
                hd = m_fir.pop_front();
                void'(m_fnpc.pop_front());
                if (hd[31:26] == HALT) begin
                    m_halted = 1;
                    m_fir.delete();
                    m_fnpc.delete();
                end
            end
            if (imem_rvalid && m_outq.size() > 0) begin
                a = m_outq.pop_front();
                if (m_drop > 0) m_drop--;
                else if (!redirect_valid) begin
                    m_fir.push_back(imem_rdata);
                    m_fnpc.push_back(a + 1);
                    if (imem_rdata[31:26] == HALT) begin
                        m_hseen = 1;
                        hpush   = 1'b1;
                    end
                end
            end
            if (e_req) begin
                m_outq.push_back(m_pc);
                m_pc = m_pc + 1;
            end
            if (hpush) m_drop = m_outq.size();
            if (redirect_valid) begin
                m_fir.delete();
                m_fnpc.delete();
                m_pc    = redirect_pc;
                m_drop  = m_outq.size();
                m_hseen = 0;
            end
        end
    end

    initial begin
        // Straight-line program, decode always ready
        do_reset(1, 1'b1);
        run_until_halt(30);
        chk_prog();
        chk("req_count", 64'(req_log.size()), 64'd4);
        for (int i = 0; i < req_log.size() && i < 4; i++) chk("req_addr", 64'(req_log[i]), 64'(i));

        // Decode stalled: only DEPTH requests, head held
        do_reset(1, 1'b0);
        step(10);
        chk("stall_req_count", 64'(req_log.size()), 64'd2);
        chk("stall_head_ir", 64'(if_ir), 64'h2801000a);
        chk("stall_head_valid", 64'(if_valid), 64'd1);
        id_ready = 1'b1;
        run_until_halt(30);
        chk_prog();

        // Redirect with two reads in flight, 3-cycle memory
        do_reset(3, 1'b1);
        step(2);
        chk("inflight_at_redirect", 64'(mq.size()), 64'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'd5;
        step(1);
        redirect_valid = 1'b0;
        xfer_ir.delete();
        xfer_npc.delete();
        run_until_halt(60);
        chk("redir_first_ir", 64'(xfer_ir.size() > 0 ? xfer_ir[0] : 32'hx), 64'h00222000);
        chk("redir_first_npc", 64'(xfer_npc.size() > 0 ? xfer_npc[0] : 32'hx), 64'd6);

        // HALT fetched but squashed by a redirect before decode takes it
        do_reset(1, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'd8;
        step(1);
        redirect_valid = 1'b0;
        for (int i = 0; i < 10 && !if_valid; i++) step(1);
        chk("halt_head_ir", 64'(if_ir), 64'hfc000000);
        redirect_valid = 1'b1;
        redirect_pc    = 32'd0;
        xfer_ir.delete();
        xfer_npc.delete();
        req_log.delete();
        step(1);
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        step(2);
        chk("halt_cleared_halted", 64'(halted), 64'd0);
        run_until_halt(30);
        chk_prog();
        chk("resume_addr", 64'(req_log.size() > 0 ? req_log[0] : 32'hx), 64'd0);

        // Reset mid-stream with a full FIFO
        do_reset(1, 1'b0);
        step(5);
        chk("pre_reset_valid", 64'(if_valid), 64'd1);
        rst_n = 1'b0;
        #2;
        chk("reset_if_valid", 64'(if_valid), 64'd0);
        chk("reset_imem_req", 64'(imem_req), 64'd0);
        step(1);
        rst_n = 1'b1;
        #2;
        chk("post_reset_req", 64'(imem_req), 64'd1);
        chk("post_reset_addr", 64'(imem_addr), 64'd0);

        // PC wrap at the top of the address space
        do_reset(1, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hffffffff;
        step(1);
        redirect_valid = 1'b0;
        run_until_halt(30);
        chk("wrap_req0", 64'(req_log.size() > 1 ? req_log[0] : 32'hx), 64'hffffffff);
        chk("wrap_req1", 64'(req_log.size() > 1 ? req_log[1] : 32'hx), 64'd0);
        chk("wrap_ir", 64'(xfer_ir.size() > 0 ? xfer_ir[0] : 32'hx), 64'h2400ffff);
        chk("wrap_npc", 64'(xfer_npc.size() > 0 ? xfer_npc[0] : 32'hx), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
